// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and width limits.
package mult_pkg;

  localparam int unsigned MULT_MIN_WIDTH = 4;
  localparam int unsigned MULT_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_seq_if.sv
// Request/response bundle between a multiplier client (master) and mult_seq (slave).
interface mult_seq_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             enable;
  logic             is_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             ready;
  logic             exception;
  logic             busy;

  modport master (
    output enable, is_signed, multiplicand, multiplier,
    input  result, result_hi, ready, exception, busy
  );

  modport slave (
    input  enable, is_signed, multiplicand, multiplier,
    output result, result_hi, ready, exception, busy
  );

endinterface

// File: rtl/mult_seq_dp.sv
// Multiplier datapath: operand magnitude/sign capture, radix-2 shift-add accumulator,
// and sign restoration of the full-width product with overflow detection.
module mult_seq_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_c,
  input  logic             step_c,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] prod_lo_c,
  output logic [WIDTH-1:0] prod_hi_c,
  output logic             exception_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic             signed_q, signed_d;

  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    acc_step_c;
  logic [PW-1:0]    prod_c;

  // Magnitudes; the most-negative value maps onto 2^(WIDTH-1) without loss.
  always_comb begin
    mag_a_c = (is_signed && multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;
    mag_b_c = (is_signed && multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;
  end

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    sum_c      = {1'b0, acc_q[PW-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    acc_step_c = {sum_c, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    signed_d = signed_q;
    if (start_c) begin
      mcand_d  = mag_a_c;
      acc_d    = {{WIDTH{1'b0}}, mag_b_c};
      neg_d    = is_signed && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      signed_d = is_signed;
    end else if (step_c) begin
      acc_d = acc_step_c;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      signed_q <= signed_d;
    end
  end

  // Product as it will stand after the current step; meaningful on the final step.
  always_comb begin
    prod_c      = (neg_q && (acc_step_c != '0)) ? (~acc_step_c + PW'(1)) : acc_step_c;
    prod_lo_c   = prod_c[WIDTH-1:0];
    prod_hi_c   = prod_c[PW-1:WIDTH];
    exception_c = signed_q ? (prod_hi_c != {WIDTH{prod_lo_c[WIDTH-1]}})
                           : (prod_hi_c != '0);
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential radix-2 multiplier: IDLE/BUSY/DONE control, iteration counter and
// registered result/handshake outputs around the mult_seq_dp datapath.
module mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  mult_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             exception_q, exception_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             start_c, step_c;
  logic [WIDTH-1:0] prod_lo_c, prod_hi_c;
  logic             exception_c;

  mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_c      (start_c),
    .step_c       (step_c),
    .is_signed    (bus.is_signed),
    .multiplicand (bus.multiplicand),
    .multiplier   (bus.multiplier),
    .prod_lo_c    (prod_lo_c),
    .prod_hi_c    (prod_hi_c),
    .exception_c  (exception_c)
  );

  // Next-state and output decode; results are captured only on the BUSY->DONE edge.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    exception_d = exception_q;
    ready_d     = 1'b0;
    start_c     = 1'b0;
    step_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          start_c   = 1'b1;
          counter_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        step_c    = 1'b1;
        counter_d = counter_q + CNT_W'(1);
        if (counter_q == LAST_ITER) begin
          result_d    = prod_lo_c;
          result_hi_d = prod_hi_c;
          exception_d = exception_c;
          state_d     = DONE;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      exception_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      exception_q <= exception_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.exception = exception_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq (WIDTH=32): directed corner cases, abort/ignore
// scenarios, back-to-back operation and random operands against an arithmetic model.
module tb_mult_seq;

  localparam int unsigned W   = 32;
  localparam int          LAT = 33;
  localparam int          PER = 34;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         exc;
    int           start;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic prev_ready = 1'b0;
  exp_t sb[$];

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: full-precision integer product, then split and range-checked.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int start);
    exp_t        e;
    longint      p;
    logic [63:0] pr;
    int          sa, sbv;
    sa  = int'(a);
    sbv = int'(b);
    if (s) begin
      p     = longint'(sa) * longint'(sbv);
      pr    = p;
      e.exc = (longint'(int'(p)) != p);
    end else begin
      pr    = {32'b0, a} * {32'b0, b};
      e.exc = (pr > 64'h0000_0000_FFFF_FFFF);
    end
    e.lo    = pr[31:0];
    e.hi    = pr[63:32];
    e.start = start;
    return e;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.ready) begin
      check("ready_one_cycle", 64'(prev_ready), 64'(0));
      if (sb.size() == 0) begin
        check("ready_expected", 64'(sb.size()), 64'(1));
      end else begin
        e = sb.pop_front();
        check("result",    64'(bus.result),    64'(e.lo));
        check("result_hi", 64'(bus.result_hi), 64'(e.hi));
        check("exception", 64'(bus.exception), 64'(e.exc));
        check("latency",   64'(cyc - e.start), 64'(LAT));
      end
    end
    prev_ready <= bus.ready;
  end

  // Called at a negedge with the DUT idle; the following rising edge is the start edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit expect_done);
    bus.enable       = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.is_signed    = s;
    if (expect_done) sb.push_back(model(a, b, s, cyc + 1));
    @(negedge clk);
    bus.enable       = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    bus.is_signed    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 120 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'(0));
    @(negedge clk);
  endtask

  logic [W-1:0] da [8] = '{32'h7FFF_FFFF, 32'd78, 32'hFFFF_FFFD, 32'h8000_0000,
                           32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [W-1:0] db [8] = '{32'h7FFF_FFFF, 32'd13, 32'h0000_0005, 32'hFFFF_FFFF,
                           32'h0000_0002, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF};
  logic         ds [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [W-1:0] edge_vals [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'hFFFF_FFFF, 32'h8000_0001};

  initial begin
    int c0;
    logic [W-1:0] ra, rb;
    bus.enable       = 1'b0;
    bus.is_signed    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;

    repeat (3) @(negedge clk);
    check("rst_result",    64'(bus.result),    64'(0));
    check("rst_result_hi", 64'(bus.result_hi), 64'(0));
    check("rst_ready",     64'(bus.ready),     64'(0));
    check("rst_exception", 64'(bus.exception), 64'(0));
    check("rst_busy",      64'(bus.busy),      64'(0));
    rst_n = 1'b1;

    // Directed corner cases, first start on the first edge after reset release.
    for (int i = 0; i < 8; i++) begin
      start_op(da[i], db[i], ds[i], 1'b1);
      check("busy_after_start", 64'(bus.busy), 64'(1));
      wait_drain();
    end

    // Enable pulse with other operands while busy must be ignored.
    start_op(32'd78, 32'd13, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    bus.enable       = 1'b1;
    bus.multiplicand = 32'h1111_1111;
    bus.multiplier   = 32'h2222_2222;
    @(negedge clk);
    bus.enable = 1'b0;
    wait_drain();

    // Asynchronous reset mid-operation: outputs clear without a clock, no ready follows.
    start_op(32'h0001_0003, 32'h0000_0101, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result",    64'(bus.result),    64'(0));
    check("abort_result_hi", 64'(bus.result_hi), 64'(0));
    check("abort_exception", 64'(bus.exception), 64'(0));
    check("abort_ready",     64'(bus.ready),     64'(0));
    check("abort_busy",      64'(bus.busy),      64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'hFFFF_FFF0, 32'h0000_0010, 1'b1, 1'b1);
    wait_drain();

    // Enable held high: three operations back to back, one every PER cycles.
    bus.enable       = 1'b1;
    bus.is_signed    = 1'b0;
    bus.multiplicand = 32'd1000;
    bus.multiplier   = 32'd3000;
    c0 = cyc + 1;
    sb.push_back(model(32'd1000, 32'd3000, 1'b0, c0));
    @(negedge clk);
    bus.is_signed    = 1'b1;
    bus.multiplicand = 32'hFFFF_FF00;
    bus.multiplier   = 32'h0000_7FFF;
    sb.push_back(model(32'hFFFF_FF00, 32'h0000_7FFF, 1'b1, c0 + PER));
    repeat (PER) @(negedge clk);
    bus.is_signed    = 1'b0;
    bus.multiplicand = 32'hDEAD_BEEF;
    bus.multiplier   = 32'h0000_0100;
    sb.push_back(model(32'hDEAD_BEEF, 32'h0000_0100, 1'b0, c0 + 2 * PER));
    repeat (PER) @(negedge clk);
    bus.enable = 1'b0;
    wait_drain();

    // Random operands, biased towards boundary values.
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
      start_op(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      wait_drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  start request; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with enable.
REQ-006 multiplicand  input  WIDTH  operand A; sampled with enable.
REQ-007 multiplier  input  WIDTH  operand B; sampled with enable.
REQ-008 result  output  WIDTH  low half of 2*WIDTH product.
REQ-009 result_hi  output  WIDTH  high half of 2*WIDTH product.
REQ-010 ready  output  1  one-cycle pulse: result, result_hi, exception valid.
REQ-011 exception  output  1  product not representable in WIDTH bits.
REQ-012 busy  output  1  high in BUSY and DONE.

Function
REQ-013 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: rising edge with enable=1 -> latch operands and is_signed, counter=0, go BUSY; enable=0 -> stay IDLE.
REQ-015 BUSY: radix-2 shift-add, one multiplier bit per cycle on magnitudes; counter increments; after WIDTH iterations go DONE.
REQ-016 Signed mode: magnitudes |A|, |B| formed at start (most-negative value maps to 2^(WIDTH-1) unsigned, no loss); final 2*WIDTH product negated iff sign(A) xor sign(B) and product nonzero.
REQ-017 DONE: ready=1 for exactly one cycle, then IDLE.
REQ-018 Latency: ready high in the cycle after the (WIDTH+1)th rising edge following the enable-sampling edge; fixed, data-independent.
REQ-019 result/result_hi/exception update only at BUSY->DONE; held stable until next BUSY->DONE.
REQ-020 exception, signed: set iff result_hi is not all copies of result[WIDTH-1].
REQ-021 exception, unsigned: set iff result_hi != 0.
REQ-022 enable in BUSY or DONE ignored; no queuing; operand changes after start have no effect.
REQ-023 enable=1 held continuously: new operation starts on first edge in IDLE after DONE (back-to-back throughput WIDTH+2 cycles).
REQ-024 Zero operand: normal latency, product 0, exception 0.

Reset
REQ-025 reset_n low: immediately (no clock) state=IDLE, counter=0, result=0, result_hi=0, ready=0, exception=0, busy=0, internal registers 0.
REQ-026 reset_n asserted mid-BUSY or in DONE aborts the operation; no ready pulse for it.
REQ-027 First enable honoured on the first rising edge after reset_n deasserts.

Structure
REQ-028 Shared package mult_pkg holds FSM state enum (IDLE, BUSY, DONE) and constants MULT_MIN_WIDTH=4, MULT_MAX_WIDTH=64.
REQ-029 Counter width $clog2(WIDTH+1), derived locally.
REQ-030 One sub-module mult_seq_dp: magnitude/sign prep, shift-add accumulator, final negation; FSM and handshake stay in mult_seq.

Verification (WIDTH=32)
REQ-031 Signed 0x7FFFFFFF * 0x7FFFFFFF -> result 0x00000001, result_hi 0x3FFFFFFF, exception 1; ready exactly 33 cycles after start edge.
REQ-032 Unsigned 78 * 13 -> result 0x000003F6, result_hi 0, exception 0.
REQ-033 Signed 0xFFFFFFFD (-3) * 5 -> result 0xFFFFFFF1, result_hi 0xFFFFFFFF, exception 0.
REQ-034 Signed 0x80000000 * 0xFFFFFFFF -> result 0x80000000, result_hi 0, exception 1; unsigned 0xFFFFFFFF * 2 -> result 0xFFFFFFFE, result_hi 1, exception 1.
REQ-035 Start 78*13, pulse enable with other operands at cycle 10 -> ignored, result 0x3F6; reset_n low at cycle 15 -> outputs 0 asynchronously, no ready; next start completes normally.
REQ-036 enable held high across 3 operations -> ready pulses every 34 cycles, each one cycle wide, results matching each operand set.
